systolic_skew_feeder: RTL and testbench

//   Upstream feeder for one edge of the systolic MAC array. Accepts one
//   N_LANES-wide operand vector per beat over a valid/ready handshake and

---
 rtl/systolic_skew_feeder.sv | 147 ++++++++++++++
 tb/tb_systolic_skew_feeder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder.sv
// Skewed operand feeder for one edge of a systolic MAC array.
// Lane i delays each accepted beat by i+1 cycles and marks tile boundaries with en/clr strobes.
module systolic_skew_feeder #(
    parameter int N_LANES = 4,
    parameter int IP_size = 8,
    parameter int K_LEN   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N_LANES*IP_size-1:0]   in_data,
    output logic [N_LANES*IP_size-1:0]   out_x,
    output logic [N_LANES-1:0]           out_en,
    output logic [N_LANES-1:0]           out_clr,
    output logic                         tile_done,
    output logic                         busy
);

    localparam int KW = (K_LEN > 1) ? $clog2(K_LEN) : 1;
    localparam int CW = (N_LANES > 1) ? $clog2(N_LANES) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [KW-1:0]      k_q, k_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               accept;
    logic               beat_first;
    logic               beat_last;
    logic [N_LANES-1:0] lane_busy;
    logic [N_LANES-1:0] last_q;

    always_comb begin
        in_ready   = !rst && (state_q != ST_DRAIN);
        accept     = in_valid && in_ready;
        beat_first = (state_q == ST_IDLE);
        if (state_q == ST_IDLE) begin
            beat_last = (K_LEN == 1);
        end else begin
            beat_last = (k_q == KW'(K_LEN - 1));
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (K_LEN == 1) begin
                        state_d = ST_DRAIN;
                        cnt_d   = CW'(N_LANES - 1);
                    end else begin
                        state_d = ST_STREAM;
                        k_d     = KW'(1);
                    end
                end
            end
            ST_STREAM: begin
                if (accept) begin
                    if (beat_last) begin
                        state_d = ST_DRAIN;
                        cnt_d   = CW'(N_LANES - 1);
                        k_d     = '0;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // Hold off the next tile until its lane N-1 clr cannot overtake this tile.
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        logic [IP_size-1:0] x_q [i+1];
        logic [i:0]         en_q;
        logic [i:0]         clr_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int j = 0; j <= i; j++) begin
                    x_q[j] <= '0;
                end
                en_q  <= '0;
                clr_q <= '0;
            end else begin
                x_q[0]   <= accept ? in_data[i*IP_size +: IP_size] : '0;
                en_q[0]  <= accept;
                clr_q[0] <= accept && beat_first;
                for (int j = 1; j <= i; j++) begin
                    x_q[j]   <= x_q[j-1];
                    en_q[j]  <= en_q[j-1];
                    clr_q[j] <= clr_q[j-1];
                end
            end
        end

        assign out_x[i*IP_size +: IP_size] = x_q[i];
        assign out_en[i]                   = en_q[i];
        assign out_clr[i]                  = clr_q[i];
        assign lane_busy[i]                = |en_q;
    end

    // The last flag only matters on the final lane, so it gets its own N-deep delay line.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= '0;
        end else begin
            last_q[0] <= accept && beat_last;
            for (int j = 1; j < N_LANES; j++) begin
                last_q[j] <= last_q[j-1];
            end
        end
    end

    always_comb begin
        tile_done = out_en[N_LANES-1] && last_q[N_LANES-1];
        busy      = (state_q != ST_IDLE) || (|lane_busy);
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder: per-lane expected slots keyed by cycle number,
// plus a K_LEN=1 instance checked with directed steps.
module tb_systolic_skew_feeder;

    localparam int N = 4;
    localparam int W = 8;
    localparam int K = 3;

    typedef struct {
        int          cyc;
        logic [W-1:0] x;
        logic        clr;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_data;
    logic [N*W-1:0] out_x;
    logic [N-1:0]   out_en;
    logic [N-1:0]   out_clr;
    logic           tile_done;
    logic           busy;

    logic           v1;
    logic           rdy1;
    logic [N*W-1:0] d1;
    logic [N*W-1:0] x1;
    logic [N-1:0]   en1;
    logic [N-1:0]   clr1;
    logic           td1;
    logic           busy1;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 1'b0;
    exp_t lane_q [N][$];
    int   done_q [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    systolic_skew_feeder #(.N_LANES(N), .IP_size(W), .K_LEN(K)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_x     (out_x),
        .out_en    (out_en),
        .out_clr   (out_clr),
        .tile_done (tile_done),
        .busy      (busy)
    );

    systolic_skew_feeder #(.N_LANES(N), .IP_size(W), .K_LEN(1)) u_k1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v1),
        .in_ready  (rdy1),
        .in_data   (d1),
        .out_x     (x1),
        .out_en    (en1),
        .out_clr   (clr1),
        .tile_done (td1),
        .busy      (busy1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc %0d: observed %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [N*W-1:0] mk(input int beat);
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'(10 * i + beat);
        return v;
    endfunction

    function automatic logic [N*W-1:0] ext(input int phase);
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = (((i + phase) % 2) == 0) ? 8'h80 : 8'h7f;
        return v;
    endfunction

    // Scoreboard check of every lane and tile_done, once per cycle.
    always @(negedge clk) begin
        if (mon_on) begin
            for (int i = 0; i < N; i++) begin
                logic [W-1:0] ex;
                logic         een;
                logic         eclr;
                ex = '0; een = 1'b0; eclr = 1'b0;
                if (lane_q[i].size() > 0 && lane_q[i][0].cyc == cyc) begin
                    een  = 1'b1;
                    ex   = lane_q[i][0].x;
                    eclr = lane_q[i][0].clr;
                    void'(lane_q[i].pop_front());
                end
                chk($sformatf("lane%0d_en", i), 32'(out_en[i]), 32'(een));
                chk($sformatf("lane%0d_clr", i), 32'(out_clr[i]), 32'(eclr));
                chk($sformatf("lane%0d_x", i), 32'(out_x[i*W +: W]), 32'(ex));
            end
            if (done_q.size() > 0 && done_q[0] == cyc) begin
                chk("tile_done", 32'(tile_done), 32'd1);
                void'(done_q.pop_front());
            end else begin
                chk("tile_done_idle", 32'(tile_done), 32'd0);
            end
        end
    end

    // Called at a negedge; the beat is accepted at the following posedge.
    task automatic drive_beat(input logic [N*W-1:0] data, input logic first, input logic last);
        exp_t e;
        in_valid = 1'b1;
        in_data  = data;
        #1;
        chk("in_ready_at_beat", 32'(in_ready), 32'd1);
        for (int i = 0; i < N; i++) begin
            e.cyc = cyc + 1 + i;
            e.x   = data[i*W +: W];
            e.clr = first;
            lane_q[i].push_back(e);
        end
        if (last) done_q.push_back(cyc + N);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_data  = N*W'($urandom);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain_check();
        for (int j = 0; j < N; j++) begin
            #1;
            chk("in_ready_drain", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        #1;
        chk("in_ready_after_drain", 32'(in_ready), 32'd1);
    endtask

    task automatic flush(input int r);
        for (int i = 0; i < N; i++) begin
            while (lane_q[i].size() > 0 && lane_q[i][$].cyc > r) void'(lane_q[i].pop_back());
        end
        while (done_q.size() > 0 && done_q[$] > r) void'(done_q.pop_back());
    endtask

    initial begin
        int c0;
        int pending;
        logic [N*W-1:0] kval;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; v1 = 1'b0; d1 = '0;
        @(negedge clk);
        mon_on = 1'b1;
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);
        chk("post_reset_k1_ready", 32'(rdy1), 32'd1);

        // Basic tile of three beats.
        drive_beat(mk(1), 1'b1, 1'b0);
        drive_beat(mk(2), 1'b0, 1'b0);
        drive_beat(mk(3), 1'b0, 1'b1);
        in_valid = 1'b0;
        chk("busy_in_drain", 32'(busy), 32'd1);
        drain_check();
        idle(6);

        // Bubble between beats 1 and 2.
        drive_beat(mk(1), 1'b1, 1'b0);
        idle(1);
        drive_beat(mk(2), 1'b0, 1'b0);
        drive_beat(mk(3), 1'b0, 1'b1);
        in_valid = 1'b0;
        drain_check();
        idle(6);

        // Back-to-back tiles with in_valid held high through the drain.
        drive_beat(mk(1), 1'b1, 1'b0);
        drive_beat(mk(2), 1'b0, 1'b0);
        drive_beat(mk(3), 1'b0, 1'b1);
        in_valid = 1'b1;
        in_data  = mk(4);
        drain_check();
        drive_beat(mk(4), 1'b1, 1'b0);
        drive_beat(mk(5), 1'b0, 1'b0);
        drive_beat(mk(6), 1'b0, 1'b1);
        in_valid = 1'b0;
        drain_check();
        idle(6);

        // K_LEN=1 instance: single beat, every lane gets en and clr together.
        for (int i = 0; i < N; i++) kval[i*W +: W] = W'(8'h51 + i);
        v1 = 1'b1;
        d1 = kval;
        #1;
        chk("k1_ready_idle", 32'(rdy1), 32'd1);
        c0 = cyc;
        @(negedge clk);
        v1 = 1'b0;
        for (int j = 1; j <= N + 1; j++) begin
            #1;
            chk($sformatf("k1_ready_c%0d", j), 32'(rdy1), 32'(j == N + 1));
            chk($sformatf("k1_done_c%0d", j), 32'(td1), 32'(j == N));
            for (int i = 0; i < N; i++) begin
                chk($sformatf("k1_en%0d_c%0d", i, j), 32'(en1[i]), 32'(j == i + 1));
                chk($sformatf("k1_clr%0d_c%0d", i, j), 32'(clr1[i]), 32'(j == i + 1));
                chk($sformatf("k1_x%0d_c%0d", i, j), 32'(x1[i*W +: W]),
                    (j == i + 1) ? 32'(kval[i*W +: W]) : 32'd0);
            end
            @(negedge clk);
        end
        chk("k1_cycle_span", 32'(cyc - c0), 32'(N + 2));

        // Signed extremes pass through bit-exact.
        drive_beat(ext(0), 1'b1, 1'b0);
        drive_beat(ext(1), 1'b0, 1'b0);
        drive_beat(ext(0), 1'b0, 1'b1);
        in_valid = 1'b0;
        drain_check();
        idle(6);

        // Reset after beat 2 discards the partial tile.
        drive_beat(mk(1), 1'b1, 1'b0);
        drive_beat(mk(2), 1'b0, 1'b0);
        rst      = 1'b1;
        in_valid = 1'b0;
        flush(cyc);
        #1;
        chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_en", 32'(out_en), 32'd0);
        chk("rst_mid_clr", 32'(out_clr), 32'd0);
        chk("rst_mid_done", 32'(tile_done), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_mid_ready_after", 32'(in_ready), 32'd1);
        drive_beat(mk(7), 1'b1, 1'b0);
        drive_beat(mk(8), 1'b0, 1'b0);
        drive_beat(mk(9), 1'b0, 1'b1);
        in_valid = 1'b0;
        drain_check();
        idle(8);

        chk("final_busy", 32'(busy), 32'd0);
        chk("final_k1_busy", 32'(busy1), 32'd0);
        pending = done_q.size();
        for (int i = 0; i < N; i++) pending += lane_q[i].size();
        chk("scoreboard_drained", 32'(pending), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
